// File: rtl/session_tx_framer.sv
// session_tx_framer
// Takes control and audio words from the session layer and sends them to the
// link as checksummed byte frames: 7E, dst, src, type, payload..., checksum.
// Audio words are buffered in a FIFO. One pending control word is held
// separately and takes priority at the next frame boundary.
module session_tx_framer #(
  parameter int         FIFO_DEPTH  = 8,
  parameter int         AUDIO_WORDS = 4,
  parameter logic [7:0] SRC_ADDR    = 8'h00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  cmd,
  input  logic [15:0] dataIn,
  input  logic [7:0]  dstPhone,
  output logic        transportBusy,
  output logic [7:0]  txData,
  output logic        txValid,
  input  logic        txReady,
  output logic        txSof,
  output logic        txEof,
  output logic [7:0]  dropCount
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam int WW = (AUDIO_WORDS > 1) ? $clog2(AUDIO_WORDS) : 1;

  localparam logic [CW-1:0] FULL_COUNT  = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] FRAME_COUNT = CW'(AUDIO_WORDS);
  localparam logic [WW-1:0] LAST_WORD   = WW'(AUDIO_WORDS - 1);

  localparam logic [1:0] CMD_CTRL   = 2'b01;
  localparam logic [1:0] CMD_AUDIO  = 2'b10;
  localparam logic [7:0] SYNC_BYTE  = 8'h7E;
  localparam logic [7:0] TYPE_CTRL  = 8'h01;
  localparam logic [7:0] TYPE_AUDIO = 8'h02;

  typedef enum logic [2:0] {IDLE, SYNC, DST, SRC, TYPE, PHI, PLO, CSUM} frameStateT;

  frameStateT state, nextState;

  logic [15:0]   fifoMem [FIFO_DEPTH];
  logic [PW-1:0] wrPtr, rdPtr, headPtr;
  logic [CW-1:0] fifoCount;
  logic          fifoFull, audioReady;

  logic [15:0]   ctrlReg;
  logic          ctrlPending;

  logic          isCtrl, nextIsCtrl;
  logic [7:0]    frameDst, nextFrameDst;
  logic [WW-1:0] wordIdx, nextWordIdx;
  logic [7:0]    sumAcc, nextSum;
  logic [7:0]    nextData;
  logic          nextValid, nextSof, nextEof;

  logic          accept, pushNow, ctrlNow, dropNow, popNow, clearCtrl, wordIsLast;
  logic [15:0]   payloadWord;

  assign fifoFull      = (fifoCount == FULL_COUNT);
  assign audioReady    = (fifoCount >= FRAME_COUNT);
  assign transportBusy = fifoFull || ctrlPending;

  assign accept     = txValid && txReady;
  assign pushNow    = (cmd == CMD_AUDIO) && !transportBusy;
  assign ctrlNow    = (cmd == CMD_CTRL) && !transportBusy;
  assign dropNow    = ((cmd == CMD_AUDIO) || (cmd == CMD_CTRL)) && transportBusy;
  assign popNow     = (state == PLO) && accept && !isCtrl;
  assign clearCtrl  = (state == CSUM) && accept && isCtrl;
  assign wordIsLast = isCtrl || (wordIdx == LAST_WORD);

  // When the current word is being popped, the next high byte comes from the following entry.
  assign headPtr     = popNow ? (rdPtr + PW'(1)) : rdPtr;
  assign payloadWord = isCtrl ? ctrlReg : fifoMem[headPtr];

  // FIFO pointers and occupancy; a push and a pop on the same edge cancel in the count.
  always_ff @(posedge clk) begin
    if (reset) begin
      wrPtr     <= '0;
      rdPtr     <= '0;
      fifoCount <= '0;
    end else begin
      if (pushNow) wrPtr <= wrPtr + PW'(1);
      if (popNow)  rdPtr <= rdPtr + PW'(1);
      if (pushNow && !popNow)      fifoCount <= fifoCount + CW'(1);
      else if (popNow && !pushNow) fifoCount <= fifoCount - CW'(1);
    end
  end

  // Audio storage; only entries between the read and write pointers are ever read.
  always_ff @(posedge clk) begin
    if (pushNow) fifoMem[wrPtr] <= dataIn;
  end

  // Pending control word, released when its checksum byte is accepted, plus the drop counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      ctrlReg     <= '0;
      ctrlPending <= 1'b0;
      dropCount   <= '0;
    end else begin
      if (ctrlNow) begin
        ctrlReg     <= dataIn;
        ctrlPending <= 1'b1;
      end else if (clearCtrl) begin
        ctrlPending <= 1'b0;
      end
      if (dropNow && (dropCount != 8'hFF)) dropCount <= dropCount + 8'd1;
    end
  end

  // Frame state plus the registered link outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      isCtrl   <= 1'b0;
      frameDst <= '0;
      wordIdx  <= '0;
      sumAcc   <= '0;
      txData   <= '0;
      txValid  <= 1'b0;
      txSof    <= 1'b0;
      txEof    <= 1'b0;
    end else begin
      state    <= nextState;
      isCtrl   <= nextIsCtrl;
      frameDst <= nextFrameDst;
      wordIdx  <= nextWordIdx;
      sumAcc   <= nextSum;
      txData   <= nextData;
      txValid  <= nextValid;
      txSof    <= nextSof;
      txEof    <= nextEof;
    end
  end

  // Next byte selection: a byte is loaded when the current one is accepted or a frame starts.
  always_comb begin
    nextState    = state;
    nextIsCtrl   = isCtrl;
    nextFrameDst = frameDst;
    nextWordIdx  = wordIdx;
    nextSum      = sumAcc;
    nextData     = txData;
    nextValid    = txValid;
    nextSof      = txSof;
    nextEof      = txEof;
    unique case (state)
      IDLE: begin
        nextValid = 1'b0;
        nextSof   = 1'b0;
        nextEof   = 1'b0;
        if (ctrlPending || audioReady) begin
          nextState    = SYNC;
          nextIsCtrl   = ctrlPending;
          nextFrameDst = ctrlPending ? ctrlReg[15:8] : dstPhone;
          nextWordIdx  = '0;
          nextSum      = '0;
          nextData     = SYNC_BYTE;
          nextValid    = 1'b1;
          nextSof      = 1'b1;
        end
      end
      default: begin
        if (accept) begin
          nextSof = 1'b0;
          nextEof = 1'b0;
          case (state)
            SYNC: begin
              nextState = DST;
              nextData  = frameDst;
              nextSum   = sumAcc + frameDst;
            end
            DST: begin
              nextState = SRC;
              nextData  = SRC_ADDR;
              nextSum   = sumAcc + SRC_ADDR;
            end
            SRC: begin
              nextState = TYPE;
              nextData  = isCtrl ? TYPE_CTRL : TYPE_AUDIO;
              nextSum   = sumAcc + (isCtrl ? TYPE_CTRL : TYPE_AUDIO);
            end
            TYPE: begin
              nextState = PHI;
              nextData  = payloadWord[15:8];
              nextSum   = sumAcc + payloadWord[15:8];
            end
            PHI: begin
              nextState = PLO;
              nextData  = payloadWord[7:0];
              nextSum   = sumAcc + payloadWord[7:0];
            end
            PLO: begin
              if (wordIsLast) begin
                nextState = CSUM;
                nextData  = 8'h00 - sumAcc;
                nextEof   = 1'b1;
              end else begin
                nextState   = PHI;
                nextWordIdx = wordIdx + WW'(1);
                nextData    = payloadWord[15:8];
                nextSum     = sumAcc + payloadWord[15:8];
              end
            end
            CSUM: begin
              nextState = IDLE;
              nextData  = 8'h00;
              nextValid = 1'b0;
            end
            default: ;
          endcase
        end
      end
    endcase
  end

endmodule

// File: tb/tb_session_tx_framer.sv
// Directed bench for session_tx_framer. Two instances share the stimulus:
// dut2 has 2 words per audio frame, dut4 keeps the default of 4.
module tb_session_tx_framer;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  cmd;
  logic [15:0] dataIn;
  logic [7:0]  dstPhone;
  logic        txReady;

  logic        busy2, valid2, sof2, eof2;
  logic [7:0]  data2, drop2;
  logic        busy4, valid4, sof4, eof4;
  logic [7:0]  data4, drop4;

  int checks = 0;
  int errors = 0;

  logic [9:0] cap2[$];
  logic [9:0] cap4[$];

  always #5 clk = ~clk;

  session_tx_framer #(.FIFO_DEPTH(8), .AUDIO_WORDS(2), .SRC_ADDR(8'h00)) dut2 (
    .clk(clk), .reset(reset), .cmd(cmd), .dataIn(dataIn), .dstPhone(dstPhone),
    .transportBusy(busy2), .txData(data2), .txValid(valid2), .txReady(txReady),
    .txSof(sof2), .txEof(eof2), .dropCount(drop2)
  );

  session_tx_framer #(.FIFO_DEPTH(8), .AUDIO_WORDS(4), .SRC_ADDR(8'h00)) dut4 (
    .clk(clk), .reset(reset), .cmd(cmd), .dataIn(dataIn), .dstPhone(dstPhone),
    .transportBusy(busy4), .txData(data4), .txValid(valid4), .txReady(txReady),
    .txSof(sof4), .txEof(eof4), .dropCount(drop4)
  );

  // Record every byte the link accepts as {eof, sof, data}; inputs are stable at the falling edge.
  always @(negedge clk) begin
    if (valid2 && txReady) cap2.push_back({eof2, sof2, data2});
    if (valid4 && txReady) cap4.push_back({eof4, sof4, data4});
  end

  // Hard stop in case something upstream loops forever.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got timeout want finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    reset   = 1'b1;
    cmd     = 2'b00;
    txReady = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    cap2.delete();
    cap4.delete();
  endtask

  task automatic sendWord(input logic [1:0] c, input logic [15:0] w);
    cmd    = c;
    dataIn = w;
    tick();
    cmd = 2'b00;
  endtask

  task automatic waitCap(input bit wide, input int n, input int budget);
    int c = 0;
    while (((wide ? cap4.size() : cap2.size()) < n) && (c < budget)) begin
      tick();
      c++;
    end
  endtask

  function automatic logic [15:0] wrapWord(input int i);
    logic [7:0] hi, lo;
    hi = 8'(i * 7 + 3);
    lo = 8'(240 - i);
    return {hi, lo};
  endfunction

  task automatic test_reset();
    reset = 1'b1; cmd = 2'b00; dataIn = 16'h0000; dstPhone = 8'h00; txReady = 1'b0;
    tick();
    tick();
    checks++; if (valid2 !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid2: got %b want 0", valid2); end
    checks++; if (sof2 !== 1'b0) begin errors++; $display("[TB] FAIL reset_sof2: got %b want 0", sof2); end
    checks++; if (eof2 !== 1'b0) begin errors++; $display("[TB] FAIL reset_eof2: got %b want 0", eof2); end
    checks++; if (data2 !== 8'h00) begin errors++; $display("[TB] FAIL reset_data2: got %h want 00", data2); end
    checks++; if (busy2 !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy2: got %b want 0", busy2); end
    checks++; if (drop2 !== 8'h00) begin errors++; $display("[TB] FAIL reset_drop2: got %h want 00", drop2); end
    checks++; if (valid4 !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid4: got %b want 0", valid4); end
    checks++; if (busy4 !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy4: got %b want 0", busy4); end
    reset = 1'b0;
    cap2.delete();
    cap4.delete();
  endtask

  task automatic test_control_frame();
    logic [7:0] expB [7] = '{8'h7E, 8'h12, 8'h00, 8'h01, 8'h12, 8'h01, 8'hDA};
    logic [9:0] want, got;
    doReset();
    txReady = 1'b1;
    sendWord(2'b01, 16'h1201);
    checks++; if (busy2 !== 1'b1) begin errors++; $display("[TB] FAIL ctrl_busy_after_accept: got %b want 1", busy2); end
    checks++; if (valid2 !== 1'b0) begin errors++; $display("[TB] FAIL ctrl_valid_early: got %b want 0", valid2); end
    tick();
    checks++; if ({valid2, sof2, data2} !== {1'b1, 1'b1, 8'h7E}) begin errors++; $display("[TB] FAIL ctrl_sync_latency: got v%b s%b %h want v1 s1 7e", valid2, sof2, data2); end
    waitCap(1'b0, 7, 40);
    checks++; if (cap2.size() != 7) begin errors++; $display("[TB] FAIL ctrl_byte_count: got %0d want 7", cap2.size()); end
    for (int k = 0; k < 7; k++) begin
      want = {k == 6, k == 0, expB[k]};
      got  = (k < cap2.size()) ? cap2[k] : 10'h3FF;
      checks++; if (got !== want) begin errors++; $display("[TB] FAIL ctrl_byte%0d: got %h want %h", k, got, want); end
    end
    checks++; if ({busy2, valid2} !== 2'b00) begin errors++; $display("[TB] FAIL ctrl_release: got busy%b valid%b want 00", busy2, valid2); end
  endtask

  task automatic test_audio_frame();
    logic [7:0] expB [9] = '{8'h7E, 8'h05, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h3B};
    logic [9:0] want, got;
    doReset();
    txReady  = 1'b1;
    dstPhone = 8'h05;
    sendWord(2'b10, 16'h1234);
    repeat (4) tick();
    checks++; if (valid2 !== 1'b0 || cap2.size() != 0) begin errors++; $display("[TB] FAIL audio_single_word: got valid%b bytes%0d want valid0 bytes0", valid2, cap2.size()); end
    sendWord(2'b10, 16'hABCD);
    waitCap(1'b0, 9, 40);
    checks++; if (cap2.size() != 9) begin errors++; $display("[TB] FAIL audio_byte_count: got %0d want 9", cap2.size()); end
    for (int k = 0; k < 9; k++) begin
      want = {k == 8, k == 0, expB[k]};
      got  = (k < cap2.size()) ? cap2[k] : 10'h3FF;
      checks++; if (got !== want) begin errors++; $display("[TB] FAIL audio_byte%0d: got %h want %h", k, got, want); end
    end
  endtask

  task automatic test_back_pressure();
    logic [7:0] expB [9] = '{8'h7E, 8'h33, 8'h00, 8'h02, 8'h10, 8'h00, 8'h10, 8'h01, 8'hAA};
    logic [9:0] want, got;
    doReset();
    dstPhone = 8'h33;
    for (int i = 0; i < 8; i++) begin
      sendWord(2'b10, 16'h1000 + 16'(i));
      if (i == 6) begin
        checks++; if (busy2 !== 1'b0) begin errors++; $display("[TB] FAIL bp_busy_at7: got %b want 0", busy2); end
      end
    end
    checks++; if (busy2 !== 1'b1) begin errors++; $display("[TB] FAIL bp_busy_full: got %b want 1", busy2); end
    sendWord(2'b10, 16'hDEAD);
    checks++; if (drop2 !== 8'h01) begin errors++; $display("[TB] FAIL bp_drop_one: got %h want 01", drop2); end
    cmd = 2'b10;
    repeat (260) tick();
    cmd = 2'b00;
    checks++; if (drop2 !== 8'hFF) begin errors++; $display("[TB] FAIL bp_drop_saturate: got %h want ff", drop2); end
    txReady = 1'b1;
    repeat (5) tick();
    checks++; if (busy2 !== 1'b1) begin errors++; $display("[TB] FAIL bp_busy_before_pop: got %b want 1", busy2); end
    tick();
    checks++; if (busy2 !== 1'b0) begin errors++; $display("[TB] FAIL bp_busy_after_pop: got %b want 0", busy2); end
    waitCap(1'b0, 9, 40);
    for (int k = 0; k < 9; k++) begin
      want = {k == 8, k == 0, expB[k]};
      got  = (k < cap2.size()) ? cap2[k] : 10'h3FF;
      checks++; if (got !== want) begin errors++; $display("[TB] FAIL bp_byte%0d: got %h want %h", k, got, want); end
    end
  endtask

  task automatic test_priority_stall();
    logic [7:0] expB [25] = '{8'h7E, 8'h44, 8'h00, 8'h02, 8'h55, 8'h66, 8'h77, 8'h88, 8'h00,
                              8'h7E, 8'h07, 8'h00, 8'h01, 8'h07, 8'h05, 8'hEC,
                              8'h7E, 8'h44, 8'h00, 8'h02, 8'h01, 8'h02, 8'h03, 8'h04, 8'hB0};
    logic [9:0] want, got;
    logic       prevValid, prevSof, prevEof, rdy;
    logic [7:0] prevData;
    int         c;
    doReset();
    dstPhone = 8'h44;
    sendWord(2'b10, 16'h5566);
    sendWord(2'b10, 16'h7788);
    sendWord(2'b10, 16'h0102);
    sendWord(2'b10, 16'h0304);
    sendWord(2'b01, 16'h0705);
    checks++; if (busy2 !== 1'b1) begin errors++; $display("[TB] FAIL prio_busy: got %b want 1", busy2); end
    checks++; if (drop2 !== 8'h00) begin errors++; $display("[TB] FAIL prio_no_drop: got %h want 00", drop2); end
    repeat (3) tick();
    checks++; if ({valid2, sof2, data2} !== {1'b1, 1'b1, 8'h7E}) begin errors++; $display("[TB] FAIL prio_parked_sync: got v%b s%b %h want v1 s1 7e", valid2, sof2, data2); end
    prevValid = valid2; prevData = data2; prevSof = sof2; prevEof = eof2;
    c = 0;
    while (cap2.size() < 25 && c < 600) begin
      rdy = 1'($urandom_range(0, 1));
      txReady = rdy;
      tick();
      c++;
      if (prevValid && !rdy) begin
        checks++;
        if (valid2 !== 1'b1 || data2 !== prevData || sof2 !== prevSof || eof2 !== prevEof) begin
          errors++; $display("[TB] FAIL prio_hold: got v%b %h s%b e%b want v1 %h s%b e%b", valid2, data2, sof2, eof2, prevData, prevSof, prevEof);
        end
      end
      prevValid = valid2; prevData = data2; prevSof = sof2; prevEof = eof2;
    end
    txReady = 1'b0;
    checks++; if (cap2.size() != 25) begin errors++; $display("[TB] FAIL prio_byte_count: got %0d want 25", cap2.size()); end
    for (int k = 0; k < 25; k++) begin
      want = {(k == 8) || (k == 15) || (k == 24), (k == 0) || (k == 9) || (k == 16), expB[k]};
      got  = (k < cap2.size()) ? cap2[k] : 10'h3FF;
      checks++; if (got !== want) begin errors++; $display("[TB] FAIL prio_byte%0d: got %h want %h", k, got, want); end
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] expB [7] = '{8'h7E, 8'h3C, 8'h00, 8'h01, 8'h3C, 8'h10, 8'h77};
    logic [9:0] want, got;
    doReset();
    dstPhone = 8'h44;
    sendWord(2'b10, 16'hA1B2);
    sendWord(2'b10, 16'hC3D4);
    tick();
    checks++; if (valid2 !== 1'b1) begin errors++; $display("[TB] FAIL rst_frame_started: got %b want 1", valid2); end
    txReady = 1'b1;
    repeat (4) tick();
    txReady = 1'b0;
    checks++; if (data2 !== 8'hA1) begin errors++; $display("[TB] FAIL rst_in_phi: got %h want a1", data2); end
    sendWord(2'b01, 16'h1111);
    sendWord(2'b01, 16'h2222);
    checks++; if (drop2 !== 8'h01) begin errors++; $display("[TB] FAIL rst_pre_drop: got %h want 01", drop2); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++; if ({valid2, eof2} !== 2'b00) begin errors++; $display("[TB] FAIL rst_truncate: got valid%b eof%b want 00", valid2, eof2); end
    checks++; if (busy2 !== 1'b0) begin errors++; $display("[TB] FAIL rst_busy_clear: got %b want 0", busy2); end
    checks++; if (drop2 !== 8'h00) begin errors++; $display("[TB] FAIL rst_drop_clear: got %h want 00", drop2); end
    cap2.delete();
    txReady = 1'b1;
    repeat (5) tick();
    checks++; if (valid2 !== 1'b0 || cap2.size() != 0) begin errors++; $display("[TB] FAIL rst_buffers_empty: got valid%b bytes%0d want valid0 bytes0", valid2, cap2.size()); end
    sendWord(2'b01, 16'h3C10);
    waitCap(1'b0, 7, 40);
    for (int k = 0; k < 7; k++) begin
      want = {k == 6, k == 0, expB[k]};
      got  = (k < cap2.size()) ? cap2[k] : 10'h3FF;
      checks++; if (got !== want) begin errors++; $display("[TB] FAIL rst_fresh_byte%0d: got %h want %h", k, got, want); end
    end
  endtask

  task automatic test_reserved_and_wrap();
    logic [9:0] wrapExp[$];
    logic [9:0] got;
    logic [7:0] sum;
    logic [15:0] w;
    int c;
    doReset();
    txReady  = 1'b1;
    dstPhone = 8'h5A;
    cmd    = 2'b11;
    dataIn = 16'hFFFF;
    repeat (6) tick();
    cmd = 2'b00;
    repeat (3) tick();
    checks++; if ({busy2, valid2, drop2} !== 10'h000 || cap2.size() != 0) begin errors++; $display("[TB] FAIL reserved_dut2: got busy%b valid%b drop%h bytes%0d want all 0", busy2, valid2, drop2, cap2.size()); end
    checks++; if ({busy4, valid4, drop4} !== 10'h000 || cap4.size() != 0) begin errors++; $display("[TB] FAIL reserved_dut4: got busy%b valid%b drop%h bytes%0d want all 0", busy4, valid4, drop4, cap4.size()); end
    for (int f = 0; f < 10; f++) begin
      wrapExp.push_back({2'b01, 8'h7E});
      wrapExp.push_back({2'b00, 8'h5A});
      wrapExp.push_back({2'b00, 8'h00});
      wrapExp.push_back({2'b00, 8'h02});
      sum = 8'h5C;
      for (int j = 0; j < 4; j++) begin
        w = wrapWord(f * 4 + j);
        wrapExp.push_back({2'b00, w[15:8]});
        wrapExp.push_back({2'b00, w[7:0]});
        sum = sum + w[15:8] + w[7:0];
      end
      wrapExp.push_back({2'b10, 8'h00 - sum});
    end
    for (int i = 0; i < 40; i++) begin
      c = 0;
      while (busy4 && c < 100) begin
        tick();
        c++;
      end
      sendWord(2'b10, wrapWord(i));
    end
    waitCap(1'b1, 130, 1000);
    checks++; if (cap4.size() != 130) begin errors++; $display("[TB] FAIL wrap_byte_count: got %0d want 130", cap4.size()); end
    for (int k = 0; k < 130; k++) begin
      got = (k < cap4.size()) ? cap4[k] : 10'h3FF;
      checks++; if (got !== wrapExp[k]) begin errors++; $display("[TB] FAIL wrap_byte%0d: got %h want %h", k, got, wrapExp[k]); end
    end
    checks++; if ({busy4, drop4} !== 9'h000) begin errors++; $display("[TB] FAIL wrap_end_state: got busy%b drop%h want 0 00", busy4, drop4); end
  endtask

  initial begin
    $display("[TB] session_tx_framer bench start");
    test_reset();
    test_control_frame();
    test_audio_frame();
    test_back_pressure();
    test_priority_stall();
    test_reset_mid_frame();
    test_reserved_and_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
